// File: rtl/whack_a_mole_core_n_if.sv
// Guess strobe and display/status bundle between the debounced front end and
// the whack-a-mole game core.
interface whack_a_mole_core_n_if #(
    parameter int NUM_HOLES = 8,
    parameter int POS_W     = 3,
    parameter int SCORE_W   = 8,
    parameter int SEC_W     = 5
);
    logic [POS_W-1:0]     user_guess;
    logic                 eval_now;
    logic [POS_W-1:0]     mole_pos;
    logic                 mole_change;
    logic                 guess_correct;
    logic                 guess_wrong;
    logic                 guess_now;
    logic [SCORE_W-1:0]   score;
    logic [NUM_HOLES-1:0] led;
    logic [SEC_W-1:0]     seconds;
    logic                 game_over;

    modport master (
        output user_guess, eval_now,
        input  mole_pos, mole_change, guess_correct, guess_wrong, guess_now,
               score, led, seconds, game_over
    );

    modport slave (
        input  user_guess, eval_now,
        output mole_pos, mole_change, guess_correct, guess_wrong, guess_now,
               score, led, seconds, game_over
    );
endinterface

// File: rtl/whack_a_mole_core_n.sv
// Parametrised whack-a-mole game core: PLAY/BLOCK/OVER FSM, LFSR mole mover,
// game timer and score. Optional streak bonus is enabled by WAM_STREAK_BONUS_EN.
module whack_a_mole_core_n #(
    parameter int NUM_HOLES      = 8,
    parameter int POS_W          = 3,
    parameter int SCORE_W        = 8,
    parameter int SEC_W          = 5,
    parameter int GAME_SECONDS   = 30,
    parameter int TICKS_PER_SEC  = 100,
    parameter int TICKS_PER_MOVE = 500,
    parameter int BLOCK_TICKS    = 300
) (
    input logic                  clk,
    input logic                  restart_game_n,
    whack_a_mole_core_n_if.slave bus
);
    localparam int MOVE_W = $clog2(TICKS_PER_MOVE + 1);
    localparam int TICK_W = $clog2(TICKS_PER_SEC + 1);
    localparam int BLK_W  = $clog2(BLOCK_TICKS + 1);

    localparam logic [MOVE_W-1:0] MOVE_LAST  = MOVE_W'(TICKS_PER_MOVE - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(BLOCK_TICKS - 1);
    localparam logic [POS_W:0]    HOLES      = (POS_W + 1)'(NUM_HOLES);
    localparam logic [POS_W-1:0]  HOLES_LAST = POS_W'(NUM_HOLES - 1);
    localparam logic [15:0]       LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {PLAY, BLOCK, OVER} state_t;

    state_t               state;
    logic [MOVE_W-1:0]    move_cnt;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BLK_W-1:0]     blk_cnt;
    logic [15:0]          lfsr;
    logic                 move_pending;
    logic [POS_W-1:0]     mole_pos;
    logic [NUM_HOLES-1:0] led;
    logic [SCORE_W-1:0]   score;
    logic [SEC_W-1:0]     seconds;
    logic                 mole_change;
    logic                 guess_correct;
    logic                 guess_wrong;
    logic                 guess_now;
    logic                 game_over;

    logic                 active;
    logic                 accept;
    logic                 hit;
    logic                 move_expire;
    logic                 do_move;
    logic                 sec_tick;
    logic                 time_up;
    logic [POS_W:0]       cand_raw;
    logic [POS_W-1:0]     cand;
    logic [POS_W-1:0]     next_pos;
    logic [NUM_HOLES-1:0] led_next;
    logic [15:0]          lfsr_next;
    logic [SCORE_W-1:0]   score_inc;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_next;

`ifdef WAM_STREAK_BONUS_EN
    logic streak;

    // Streak survives correct-guess moves; only a miss or a timeout move breaks it.
    always_ff @(posedge clk) begin
        if (!restart_game_n) begin
            streak <= 1'b0;
        end else if (accept) begin
            streak <= hit;
        end else if (move_expire) begin
            streak <= 1'b0;
        end
    end
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        active      = (state != OVER);
        accept      = bus.eval_now && (state == PLAY);
        hit         = accept && ({1'b0, bus.user_guess} < HOLES) && (bus.user_guess == mole_pos);
        move_expire = active && (move_cnt == MOVE_LAST);
        do_move     = active && (move_expire || move_pending);
        sec_tick    = active && (tick_cnt == TICK_LAST);
        time_up     = sec_tick && (seconds == SEC_W'(1));

        // 2^(POS_W-1) < NUM_HOLES, so a single subtraction folds any LFSR value into range.
        cand_raw = {1'b0, lfsr[POS_W-1:0]};
        cand     = (cand_raw >= HOLES) ? POS_W'(cand_raw - HOLES) : POS_W'(cand_raw);
        next_pos = cand;
        if (cand == mole_pos) begin
            next_pos = (mole_pos == HOLES_LAST) ? '0 : mole_pos + POS_W'(1);
        end
        led_next  = NUM_HOLES'(1) << next_pos;
        lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

`ifdef WAM_STREAK_BONUS_EN
        score_inc = streak ? SCORE_W'(2) : SCORE_W'(1);
`else
        score_inc = SCORE_W'(1);
`endif
        score_sum  = {1'b0, score} + {1'b0, score_inc};
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!restart_game_n) begin
            state         <= PLAY;
            move_cnt      <= '0;
            tick_cnt      <= '0;
            blk_cnt       <= '0;
            lfsr          <= LFSR_SEED;
            move_pending  <= 1'b0;
            mole_pos      <= '0;
            led           <= NUM_HOLES'(1);
            score         <= '0;
            seconds       <= SEC_W'(GAME_SECONDS);
            mole_change   <= 1'b0;
            guess_correct <= 1'b0;
            guess_wrong   <= 1'b0;
            guess_now     <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            guess_correct <= hit;
            guess_wrong   <= accept && !hit;
            mole_change   <= do_move;
            // An expiry in the accept cycle already moves the mole; don't move twice.
            move_pending  <= hit && !move_expire;
            if (hit) begin
                score <= score_next;
            end

            if (do_move) begin
                mole_pos <= next_pos;
                led      <= led_next;
                lfsr     <= lfsr_next;
                move_cnt <= '0;
            end else if (active) begin
                move_cnt <= move_cnt + MOVE_W'(1);
            end

            if (sec_tick) begin
                tick_cnt <= '0;
                seconds  <= seconds - SEC_W'(1);
            end else if (active) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end

            case (state)
                PLAY: begin
                    guess_now <= !accept;
                    if (accept) begin
                        state   <= BLOCK;
                        blk_cnt <= '0;
                    end
                end
                BLOCK: begin
                    guess_now <= (blk_cnt == BLK_LAST);
                    if (blk_cnt == BLK_LAST) begin
                        state <= PLAY;
                    end else begin
                        blk_cnt <= blk_cnt + BLK_W'(1);
                    end
                end
                default: guess_now <= 1'b0;
            endcase

            // Running out of time overrides any PLAY/BLOCK transition above.
            if (time_up) begin
                state     <= OVER;
                guess_now <= 1'b0;
                game_over <= 1'b1;
                led       <= '0;
            end
        end
    end

    assign bus.mole_pos      = mole_pos;
    assign bus.mole_change   = mole_change;
    assign bus.guess_correct = guess_correct;
    assign bus.guess_wrong   = guess_wrong;
    assign bus.guess_now     = guess_now;
    assign bus.score         = score;
    assign bus.led           = led;
    assign bus.seconds       = seconds;
    assign bus.game_over     = game_over;
endmodule

// File: tb/tb_whack_a_mole_core_n.sv
// Self-checking bench for whack_a_mole_core_n: vector table of single guesses
// plus hand sequences, with a scoreboard queue for hit/miss pulses.
module tb_whack_a_mole_core_n;
    localparam int NH  = 5;
    localparam int PW  = 3;
    localparam int SW  = 8;
    localparam int SCW = 5;
    localparam int GS  = 3;

    logic clk;
    logic restart_game_n;

    whack_a_mole_core_n_if #(.NUM_HOLES(NH), .POS_W(PW), .SCORE_W(SW), .SEC_W(SCW)) bus ();

    whack_a_mole_core_n #(
        .NUM_HOLES(NH), .POS_W(PW), .SCORE_W(SW), .SEC_W(SCW), .GAME_SECONDS(GS),
        .TICKS_PER_SEC(10), .TICKS_PER_MOVE(20), .BLOCK_TICKS(4)
    ) dut (
        .clk(clk),
        .restart_game_n(restart_game_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit hit;
        int score;
    } exp_t;

    typedef struct {
        int wait_cyc;   // PLAY cycles before the guess
        int mode;       // 0: model mole_pos + val (mod NH); 1: absolute val
        int val;
        bit hit;
        int exp_score;
    } vec_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] m_lfsr;
    int          m_pos;
    int          exp_score;
    bit          m_streak;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    function automatic int pick_pos(input logic [15:0] s, input int pos);
        int c;
        c = int'(s[2:0]);
        if (c >= NH) c = c - NH;
        if (c == pos) c = (pos + 1) % NH;
        return c;
    endfunction

    task automatic model_move();
        m_pos  = pick_pos(m_lfsr, m_pos);
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic push_expect(input bit h);
        int inc;
        if (h) begin
            inc = 1;
`ifdef WAM_STREAK_BONUS_EN
            if (m_streak) inc = 2;
`endif
            exp_score = (exp_score + inc > 255) ? 255 : exp_score + inc;
            m_streak  = 1'b1;
        end else begin
            m_streak = 1'b0;
        end
        sb.push_back('{hit: h, score: exp_score});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Scoreboard monitor: every result pulse must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (bus.guess_correct || bus.guess_wrong) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse (cycle %0d): got correct=%0d wrong=%0d, expected no pulse",
                             cyc, bus.guess_correct, bus.guess_wrong);
                end else begin
                    e = sb.pop_front();
                    check("pulse_correct", int'(bus.guess_correct), int'(e.hit));
                    check("pulse_wrong", int'(bus.guess_wrong), int'(!e.hit));
                    check("pulse_score", int'(bus.score), e.score);
                end
            end
        end
    end

    task automatic reset_dut();
        restart_game_n = 1'b0;
        bus.eval_now   = 1'b0;
        bus.user_guess = '0;
        step();
        step();
        check("rst_score", int'(bus.score), 0);
        check("rst_seconds", int'(bus.seconds), GS);
        check("rst_mole_pos", int'(bus.mole_pos), 0);
        check("rst_led", int'(bus.led), 1);
        check("rst_game_over", int'(bus.game_over), 0);
        check("rst_guess_now", int'(bus.guess_now), 0);
        check("rst_pulses", int'({bus.mole_change, bus.guess_correct, bus.guess_wrong}), 0);
        restart_game_n = 1'b1;
        cyc       = 0;
        m_lfsr    = 16'hACE1;
        m_pos     = 0;
        exp_score = 0;
        m_streak  = 1'b0;
    endtask

    // One accepted guess at the next edge, a blocked retry, and the lockout window.
    task automatic run_eval(input int g, input bit h);
        bus.user_guess = PW'(g);
        bus.eval_now   = 1'b1;
        push_expect(h);
        step();
        bus.eval_now = 1'b0;
        check("block_guess_now0", int'(bus.guess_now), 0);
        step();
        if (h) model_move();
        check("eval_mole_change", int'(bus.mole_change), int'(h));
        check("eval_mole_pos", int'(bus.mole_pos), m_pos);
        bus.user_guess = PW'(m_pos);
        bus.eval_now   = 1'b1;
        step();
        bus.eval_now = 1'b0;
        check("block_guess_now2", int'(bus.guess_now), 0);
        step();
        check("block_guess_now3", int'(bus.guess_now), 0);
        step();
        check("block_end_guess_now", int'(bus.guess_now), 1);
        check("block_score", int'(bus.score), exp_score);
    endtask

    initial begin
        vec_t vecs[6];
        int   g;

        restart_game_n = 1'b0;
        bus.eval_now   = 1'b0;
        bus.user_guess = '0;

        // Idle game: one timeout move at 20, timer 3,2,1,0, game over at 30, no move at 40.
        reset_dut();
        for (int k = 1; k <= 45; k++) begin
            step();
            if (cyc == 20) model_move();
            check("idle_mole_change", int'(bus.mole_change), int'(cyc == 20));
            check("idle_mole_pos", int'(bus.mole_pos), m_pos);
            check("idle_led", int'(bus.led), (cyc >= 30) ? 0 : (1 << m_pos));
            check("idle_seconds", int'(bus.seconds), (cyc < 10) ? 3 : (cyc < 20) ? 2 : (cyc < 30) ? 1 : 0);
            check("idle_game_over", int'(bus.game_over), int'(cyc >= 30));
            check("idle_guess_now", int'(bus.guess_now), int'(cyc < 30));
        end

        // Single guesses from a fresh game each.
        vecs[0] = '{wait_cyc: 1, mode: 0, val: 0, hit: 1'b1, exp_score: 1};
        vecs[1] = '{wait_cyc: 3, mode: 0, val: 1, hit: 1'b0, exp_score: 0};
        vecs[2] = '{wait_cyc: 2, mode: 1, val: 6, hit: 1'b0, exp_score: 0};
        vecs[3] = '{wait_cyc: 5, mode: 1, val: 7, hit: 1'b0, exp_score: 0};
        vecs[4] = '{wait_cyc: 4, mode: 1, val: 5, hit: 1'b0, exp_score: 0};
        vecs[5] = '{wait_cyc: 6, mode: 0, val: 4, hit: 1'b0, exp_score: 0};
        for (int i = 0; i < 6; i++) begin
            reset_dut();
            repeat (vecs[i].wait_cyc) step();
            g = (vecs[i].mode == 0) ? (m_pos + vecs[i].val) % NH : vecs[i].val;
            run_eval(g, vecs[i].hit);
            check("vec_score", int'(bus.score), vecs[i].exp_score);
            check("vec_pending", sb.size(), 0);
        end

        // Three hits, a miss, a hit: accepts at cycles 2, 7, 12, 17, 22.
        reset_dut();
        step();
        run_eval(m_pos, 1'b1);
        run_eval(m_pos, 1'b1);
        run_eval(m_pos, 1'b1);
`ifdef WAM_STREAK_BONUS_EN
        check("streak_three_hits", int'(bus.score), 5);
`else
        check("streak_three_hits", int'(bus.score), 3);
`endif
        run_eval((m_pos + 2) % NH, 1'b0);
        run_eval(m_pos, 1'b1);
`ifdef WAM_STREAK_BONUS_EN
        check("streak_miss_hit", int'(bus.score), 6);
`else
        check("streak_miss_hit", int'(bus.score), 4);
`endif
        check("streak_pending", sb.size(), 0);

        // eval_now held with a correct guess: accepted at 25 and again at 30 as time runs out.
        reset_dut();
        repeat (20) step();
        model_move();
        m_streak = 1'b0;
        check("over_first_move", int'(bus.mole_pos), m_pos);
        repeat (4) step();
        for (int k = 0; k < 16; k++) begin
            bus.user_guess = PW'(m_pos);
            bus.eval_now   = 1'b1;
            if (cyc == 24 || cyc == 29) push_expect(1'b1);
            step();
            if (cyc == 26) begin
                model_move();
                check("over_hit_move", int'(bus.mole_change), 1);
            end
            if (cyc == 30) begin
                check("over_game_over", int'(bus.game_over), 1);
                check("over_seconds", int'(bus.seconds), 0);
                check("over_guess_now", int'(bus.guess_now), 0);
            end
            if (cyc > 30) begin
                check("over_led", int'(bus.led), 0);
                check("over_no_move", int'(bus.mole_change), 0);
                check("over_score_frozen", int'(bus.score), exp_score);
                check("over_mole_frozen", int'(bus.mole_pos), m_pos);
            end
        end
        bus.eval_now = 1'b0;
`ifdef WAM_STREAK_BONUS_EN
        check("over_final_score", int'(bus.score), 3);
`else
        check("over_final_score", int'(bus.score), 2);
`endif
        check("over_pending", sb.size(), 0);

        // One-cycle restart in the middle of the lockout.
        reset_dut();
        step();
        bus.user_guess = PW'(m_pos);
        bus.eval_now   = 1'b1;
        push_expect(1'b1);
        step();
        bus.eval_now = 1'b0;
        step();
        restart_game_n = 1'b0;
        step();
        check("midrst_score", int'(bus.score), 0);
        check("midrst_seconds", int'(bus.seconds), GS);
        check("midrst_mole_pos", int'(bus.mole_pos), 0);
        check("midrst_led", int'(bus.led), 1);
        check("midrst_pulses", int'({bus.mole_change, bus.guess_correct, bus.guess_wrong}), 0);
        check("midrst_guess_now", int'(bus.guess_now), 0);
        restart_game_n = 1'b1;
        step();
        check("midrst_play", int'(bus.guess_now), 1);
        check("midrst_no_move", int'(bus.mole_change), 0);
        step();
        check("midrst_pending", sb.size(), 0);

        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
